// File: rtl/cnn_layer_accel_awe_rb_arb_pkg.sv
// Shared types for the AWE row-buffer arbiter.
// Optional macro: CNN_LAYER_ACCEL_AWE_RB_ARB_PERF_EN (see top).
package cnn_layer_accel_awe_rb_arb_pkg;
   localparam int NUM_CE = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   typedef logic        ce_id_t;
   typedef logic [15:0] pos_t;

   function automatic pos_t eff_dim(input pos_t d);
      return (d == 16'd0) ? 16'd1 : d;
   endfunction
endpackage

// File: rtl/cnn_layer_accel_awe_rb_arb_if.sv
// Output beat stream from the arbiter to the row-buffer write port.
// Optional macro: none.
interface cnn_layer_accel_awe_rb_arb_if #(
   parameter int DW = 32
);
   import cnn_layer_accel_awe_rb_arb_pkg::*;

   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   ce_id_t        out_ce_id;
   pos_t          out_row;
   pos_t          out_col;
   logic          out_last_kernel;

   modport master (
      output out_data, out_valid, out_ce_id,
      output out_row, out_col, out_last_kernel,
      input  out_ready
   );

   modport slave (
      input  out_data, out_valid, out_ce_id,
      input  out_row, out_col, out_last_kernel,
      output out_ready
   );
endinterface

// File: rtl/cnn_layer_accel_awe_rb_arb_fifo.sv
// Per-CE synchronous FIFO; pop is applied before push so full+pop+push is legal.
// Optional macro: none.
module cnn_layer_accel_awe_rb_arb_fifo #(
   parameter int W     = 33,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     afull
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C = CW'(DEPTH - 1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic          do_pop;
   logic          do_push;

   assign empty   = (count == '0);
   assign full    = (count == FULL_C);
   assign afull   = (count >= AFULL_C);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rp];

   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (do_push) wp <= wp + AW'(1);
         if (do_pop)  rp <= rp + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/cnn_layer_accel_awe_rowbuffer_arb.sv
// Two-CE round-robin arbiter onto the row-buffer port with position tagging.
// Optional macro: CNN_LAYER_ACCEL_AWE_RB_ARB_PERF_EN adds stall perf counters.
module cnn_layer_accel_awe_rowbuffer_arb
   import cnn_layer_accel_awe_rb_arb_pkg::*;
#(
   parameter int C_PIXEL_WIDTH    = 16,
   parameter int C_NUM_CE_PER_AWE = 2,
   parameter int C_FIFO_DEPTH     = 4,
   localparam int C_DW = C_PIXEL_WIDTH * C_NUM_CE_PER_AWE
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cfg_start,
   input  pos_t            cfg_num_out_rows,
   input  pos_t            cfg_num_out_cols,
   input  logic [C_DW-1:0] ce0_pixel_dataout,
   input  logic [C_DW-1:0] ce1_pixel_dataout,
   input  logic            ce0_pixel_dataout_valid,
   input  logic            ce1_pixel_dataout_valid,
   input  logic            ce0_last_kernel,
   input  logic            ce1_last_kernel,
   output logic            ce0_stall,
   output logic            ce1_stall,
   cnn_layer_accel_awe_rb_arb_if.master rb,
   output logic            done,
   output logic            err_overflow
`ifdef CNN_LAYER_ACCEL_AWE_RB_ARB_PERF_EN
   ,
   output logic [31:0]     perf_stall_ce0,
   output logic [31:0]     perf_stall_ce1
`endif
);
   localparam int CW = $clog2(C_FIFO_DEPTH) + 1;
   localparam int EW = C_DW + 1;

   state_t            st;
   pos_t              rows_q;
   pos_t              cols_q;
   logic [31:0]       total_q;
   ce_id_t            last_g;
   ce_id_t            gnt;
   logic              gnt_v;
   logic              free;
   logic              run;
   logic              start_ok;

   logic [NUM_CE-1:0] vin;
   logic [NUM_CE-1:0] lkin;
   logic [NUM_CE-1:0] push;
   logic [NUM_CE-1:0] pop;
   logic [NUM_CE-1:0] ovf;
   logic [NUM_CE-1:0] pdone;
   logic [NUM_CE-1:0] fin;
   logic [NUM_CE-1:0] full;
   logic [NUM_CE-1:0] empty;
   logic [NUM_CE-1:0] afull;
   logic [C_DW-1:0]   din  [NUM_CE];
   logic [EW-1:0]     rdat [NUM_CE];
   logic [CW-1:0]     cnt  [NUM_CE];
   logic [31:0]       pcnt [NUM_CE];
   pos_t              row  [NUM_CE];
   pos_t              col  [NUM_CE];

   assign vin      = {ce1_pixel_dataout_valid, ce0_pixel_dataout_valid};
   assign lkin     = {ce1_last_kernel, ce0_last_kernel};
   assign din[0]   = ce0_pixel_dataout;
   assign din[1]   = ce1_pixel_dataout;
   assign ce0_stall = afull[0];
   assign ce1_stall = afull[1];
   assign run      = (st == ST_RUN);
   assign start_ok = cfg_start & ((st == ST_IDLE) | (st == ST_DONE));
   assign free     = ~rb.out_valid | rb.out_ready;

   for (genvar c = 0; c < NUM_CE; c++) begin : g_ce
      cnn_layer_accel_awe_rb_arb_fifo #(
         .W     (EW),
         .DEPTH (C_FIFO_DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst_n (rst_n),
         .push  (push[c]),
         .pop   (pop[c]),
         .wdata ({lkin[c], din[c]}),
         .rdata (rdat[c]),
         .count (cnt[c]),
         .full  (full[c]),
         .empty (empty[c]),
         .afull (afull[c])
      );
   end

   // Tie goes to the CE that did not win last time.
   always_comb begin
      gnt_v = 1'b0;
      gnt   = 1'b0;
      if (free) begin
         unique case (1'b1)
            (~empty[0] & ~empty[1]): begin
               gnt_v = 1'b1;
               gnt   = ~last_g;
            end
            (~empty[0] & empty[1]): begin
               gnt_v = 1'b1;
               gnt   = 1'b0;
            end
            (empty[0] & ~empty[1]): begin
               gnt_v = 1'b1;
               gnt   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign pop[0] = gnt_v & ~gnt;
   assign pop[1] = gnt_v & gnt;

   always_comb begin
      push  = '0;
      ovf   = '0;
      pdone = '0;
      for (int c = 0; c < NUM_CE; c++) begin
         pdone[c] = (pcnt[c] == total_q);
         push[c]  = run & vin[c] & ~pdone[c] & ~fin[c]
                  & (~full[c] | pop[c]);
         ovf[c]   = run & vin[c]
                  & (pdone[c] | fin[c] | (full[c] & ~pop[c]));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_CE; c++) begin
            pcnt[c] <= '0;
            row[c]  <= '0;
            col[c]  <= '0;
         end
         fin <= '0;
      end else if (start_ok) begin
         for (int c = 0; c < NUM_CE; c++) begin
            pcnt[c] <= '0;
            row[c]  <= '0;
            col[c]  <= '0;
         end
         fin <= '0;
      end else begin
         for (int c = 0; c < NUM_CE; c++) begin
            if (push[c] & lkin[c]) pcnt[c] <= pcnt[c] + 32'd1;
            if (pop[c] & rdat[c][C_DW]) begin
               if (col[c] == cols_q - 16'd1) begin
                  col[c] <= '0;
                  if (row[c] == rows_q - 16'd1) fin[c] <= 1'b1;
                  else row[c] <= row[c] + 16'd1;
               end else begin
                  col[c] <= col[c] + 16'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st                 <= ST_IDLE;
         rows_q             <= '0;
         cols_q             <= '0;
         total_q            <= '0;
         last_g             <= 1'b1;
         done               <= 1'b0;
         err_overflow       <= 1'b0;
         rb.out_valid       <= 1'b0;
         rb.out_data        <= '0;
         rb.out_ce_id       <= 1'b0;
         rb.out_row         <= '0;
         rb.out_col         <= '0;
         rb.out_last_kernel <= 1'b0;
      end else begin
         if (|ovf) err_overflow <= 1'b1;

         if (gnt_v) begin
            rb.out_valid       <= 1'b1;
            rb.out_data        <= rdat[gnt][C_DW-1:0];
            rb.out_last_kernel <= rdat[gnt][C_DW];
            rb.out_ce_id       <= gnt;
            rb.out_row         <= row[gnt];
            rb.out_col         <= col[gnt];
            last_g             <= gnt;
         end else if (rb.out_ready) begin
            rb.out_valid <= 1'b0;
         end

         if (start_ok) begin
            rows_q  <= eff_dim(cfg_num_out_rows);
            cols_q  <= eff_dim(cfg_num_out_cols);
            total_q <= {16'd0, eff_dim(cfg_num_out_rows)}
                     * {16'd0, eff_dim(cfg_num_out_cols)};
         end

         unique case (st)
            ST_IDLE: begin
               if (cfg_start) st <= ST_RUN;
            end
            ST_RUN: begin
               if (&pdone) st <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if ((cnt[0] == '0) & (cnt[1] == '0) & ~rb.out_valid)
                  st <= ST_DONE;
            end
            ST_DONE: begin
               if (cfg_start) begin
                  st   <= ST_RUN;
                  done <= 1'b0;
               end else begin
                  done <= 1'b1;
               end
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

`ifdef CNN_LAYER_ACCEL_AWE_RB_ARB_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_ce0 <= '0;
         perf_stall_ce1 <= '0;
      end else if (start_ok) begin
         perf_stall_ce0 <= '0;
         perf_stall_ce1 <= '0;
      end else if (run) begin
         if (ce0_stall & (perf_stall_ce0 != '1))
            perf_stall_ce0 <= perf_stall_ce0 + 32'd1;
         if (ce1_stall & (perf_stall_ce1 != '1))
            perf_stall_ce1 <= perf_stall_ce1 + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_cnn_layer_accel_awe_rowbuffer_arb.sv
// Bench for the AWE row-buffer arbiter: vector table, directed corners,
// randomized layers against a queue-based reference model.
module tb_cnn_layer_accel_awe_rowbuffer_arb;
   localparam int DW = 32;
   localparam int D  = 4;
   localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2, S_DONE = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cfg_start = 1'b0;
   logic [15:0]   cfg_rows = '0;
   logic [15:0]   cfg_cols = '0;
   logic [DW-1:0] d0 = '0, d1 = '0;
   logic          v0 = 1'b0, v1 = 1'b0, lk0 = 1'b0, lk1 = 1'b0;
   logic          stall0, stall1, done, err;

   cnn_layer_accel_awe_rb_arb_if #(.DW(DW)) rb_if ();

   cnn_layer_accel_awe_rowbuffer_arb dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .cfg_start               (cfg_start),
      .cfg_num_out_rows        (cfg_rows),
      .cfg_num_out_cols        (cfg_cols),
      .ce0_pixel_dataout       (d0),
      .ce1_pixel_dataout       (d1),
      .ce0_pixel_dataout_valid (v0),
      .ce1_pixel_dataout_valid (v1),
      .ce0_last_kernel         (lk0),
      .ce1_last_kernel         (lk1),
      .ce0_stall               (stall0),
      .ce1_stall               (stall1),
      .rb                      (rb_if),
      .done                    (done),
      .err_overflow            (err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: FIFOs as queues, positions as a flat beat index.
   typedef logic [DW:0] ent_t;
   ent_t          q0[$], q1[$];
   int            m_st, m_cols, m_lg;
   longint        m_tot;
   int            m_np[2], m_idx[2];
   bit            m_fin[2];
   bit            m_ov, m_olk, m_done, m_err;
   logic [DW-1:0] m_od;
   int            m_oid, m_orow, m_ocol;

   function automatic int eff(input logic [15:0] x);
      return (x == 16'd0) ? 1 : int'(x);
   endfunction

   function automatic void m_reset();
      q0.delete(); q1.delete();
      m_st = S_IDLE; m_tot = 0; m_cols = 1; m_lg = 1;
      m_np = '{0, 0}; m_idx = '{0, 0}; m_fin = '{0, 0};
      m_ov = 0; m_olk = 0; m_done = 0; m_err = 0;
      m_od = '0; m_oid = 0; m_orow = 0; m_ocol = 0;
   endfunction

   function automatic void m_edge();
      int sz[2]; bit v[2]; bit lk[2]; logic [DW-1:0] d[2]; bit acc[2];
      int g; bit free, to_drain, to_done, start_ok; ent_t e;
      sz[0] = q0.size(); sz[1] = q1.size();
      v = '{v0, v1}; lk = '{lk0, lk1}; d = '{d0, d1};
      free = !m_ov || rb_if.out_ready;
      g = -1;
      if (free) begin
         if (sz[0] > 0 && sz[1] > 0) g = 1 - m_lg;
         else if (sz[0] > 0) g = 0;
         else if (sz[1] > 0) g = 1;
      end
      to_drain = m_st == S_RUN && m_np[0] == m_tot && m_np[1] == m_tot;
      to_done  = m_st == S_DRAIN && sz[0] == 0 && sz[1] == 0 && !m_ov;
      start_ok = cfg_start && (m_st == S_IDLE || m_st == S_DONE);
      for (int c = 0; c < 2; c++) begin
         acc[c] = 0;
         if (m_st == S_RUN && v[c]) begin
            if (m_np[c] == m_tot || m_fin[c] || (sz[c] == D && g != c))
               m_err = 1;
            else acc[c] = 1;
         end
      end
      if (g >= 0) begin
         if (g == 0) e = q0.pop_front(); else e = q1.pop_front();
         m_ov = 1; m_od = e[DW-1:0]; m_olk = e[DW]; m_oid = g;
         m_orow = m_idx[g] / m_cols; m_ocol = m_idx[g] % m_cols;
         if (e[DW]) begin
            m_idx[g]++;
            if (m_idx[g] == m_tot) m_fin[g] = 1;
         end
         m_lg = g;
      end else if (free) m_ov = 0;
      for (int c = 0; c < 2; c++) if (acc[c]) begin
         if (lk[c]) m_np[c]++;
         if (c == 0) q0.push_back({lk[c], d[c]});
         else q1.push_back({lk[c], d[c]});
      end
      m_done = (m_st == S_DONE) && !cfg_start;
      if (start_ok) begin
         m_st = S_RUN; m_cols = eff(cfg_cols);
         m_tot = longint'(eff(cfg_rows)) * m_cols;
         m_np = '{0, 0}; m_idx = '{0, 0}; m_fin = '{0, 0};
      end else if (to_drain) m_st = S_DRAIN;
      else if (to_done) m_st = S_DONE;
   endfunction

   task automatic cmp_all(input string t);
      chk({t, ".valid"}, rb_if.out_valid, m_ov);
      if (m_ov) begin
         chk({t, ".data"}, rb_if.out_data, m_od);
         chk({t, ".id"}, rb_if.out_ce_id, m_oid);
         chk({t, ".row"}, rb_if.out_row, m_orow);
         chk({t, ".col"}, rb_if.out_col, m_ocol);
         chk({t, ".lk"}, rb_if.out_last_kernel, m_olk);
      end
      chk({t, ".stall0"}, stall0, q0.size() >= D - 1);
      chk({t, ".stall1"}, stall1, q1.size() >= D - 1);
      chk({t, ".done"}, done, m_done);
      chk({t, ".err"}, err, m_err);
   endtask

   task automatic step(input string t);
      @(posedge clk);
      if (rst_n) m_edge();
      #1;
      cmp_all(t);
   endtask

   task automatic idle_in();
      v0 = 0; v1 = 0; lk0 = 0; lk1 = 0; cfg_start = 0;
   endtask

   task automatic chk_reset_vals(input string t);
      chk({t, ".rvalid"}, rb_if.out_valid, 0);
      chk({t, ".rdata"}, rb_if.out_data, 0);
      chk({t, ".rrow"}, rb_if.out_row, 0);
      chk({t, ".rcol"}, rb_if.out_col, 0);
      chk({t, ".rid"}, rb_if.out_ce_id, 0);
      chk({t, ".rlk"}, rb_if.out_last_kernel, 0);
      chk({t, ".rstall"}, {stall0, stall1}, 0);
      chk({t, ".rdone"}, done, 0);
      chk({t, ".rerr"}, err, 0);
   endtask

   task automatic hard_reset(input string t);
      #2 rst_n = 0;
      m_reset();
      idle_in();
      #1 chk_reset_vals(t);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
   endtask

   task automatic start(input int r, input int c);
      cfg_rows = 16'(r); cfg_cols = 16'(c);
      cfg_start = 1;
      step("start");
      cfg_start = 0;
   endtask

   task automatic wait_done(input string t, input int lim);
      bit seen = 0;
      idle_in();
      for (int i = 0; i < lim && !seen; i++) begin
         step(t);
         if (done) seen = 1;
      end
      chk({t, ".done_reached"}, seen, 1);
   endtask

   typedef struct {
      bit          v0;
      logic [31:0] d;
      bit          ev;
      int          er;
      int          ec;
      logic [31:0] ed;
   } vec_t;
   vec_t tbl[8];

   int ids[$];
   int rr[$], cc[$];

   initial begin
      tbl[0] = '{1, 32'h100, 0, 0, 0, 32'h0};
      tbl[1] = '{1, 32'h101, 1, 0, 0, 32'h100};
      tbl[2] = '{1, 32'h102, 1, 0, 1, 32'h101};
      tbl[3] = '{1, 32'h103, 1, 0, 2, 32'h102};
      tbl[4] = '{1, 32'h104, 1, 1, 0, 32'h103};
      tbl[5] = '{1, 32'h105, 1, 1, 1, 32'h104};
      tbl[6] = '{0, 32'h0,   1, 1, 2, 32'h105};
      tbl[7] = '{0, 32'h0,   0, 0, 0, 32'h0};

      rb_if.out_ready = 0;
      m_reset();
      #12 chk_reset_vals("por");
      @(posedge clk); #1 rst_n = 1;

      // 2x3 layer, CE0 only via table, then CE1 completes it
      rb_if.out_ready = 1;
      start(2, 3);
      for (int i = 0; i < 8; i++) begin
         v0 = tbl[i].v0; lk0 = 1; d0 = tbl[i].d;
         step("tbl");
         chk("tbl.valid", rb_if.out_valid, tbl[i].ev);
         if (tbl[i].ev) begin
            chk("tbl.row", rb_if.out_row, tbl[i].er);
            chk("tbl.col", rb_if.out_col, tbl[i].ec);
            chk("tbl.data", rb_if.out_data, tbl[i].ed);
            chk("tbl.id", rb_if.out_ce_id, 0);
         end
      end
      chk("t1.done_early", done, 0);
      for (int i = 0; i < 6; i++) begin
         v1 = 1; lk1 = 1; d1 = $urandom;
         step("t1.ce1");
      end
      wait_done("t1", 20);

      // round-robin alternation
      hard_reset("t2r");
      rb_if.out_ready = 1;
      start(4, 4);
      ids.delete();
      for (int i = 0; i < 9; i++) begin
         v0 = i < 3; v1 = i < 3; lk0 = 1; lk1 = 1;
         d0 = $urandom; d1 = $urandom;
         step("t2");
         if (rb_if.out_valid) ids.push_back(int'(rb_if.out_ce_id));
         chk("t2.nostall", {stall0, stall1}, 0);
      end
      chk("t2.count", ids.size(), 6);
      foreach (ids[k]) chk("t2.alt", ids[k], k % 2);

      // backpressure, almost-full and overflow
      hard_reset("t3r");
      rb_if.out_ready = 0;
      start(4, 4);
      for (int i = 0; i < 6; i++) begin
         v0 = 1; lk0 = 1; d0 = 32'h1000 + i;
         step("t3");
         chk("t3.valid", rb_if.out_valid, i >= 1);
         if (i >= 1) chk("t3.held", rb_if.out_data, 32'h1000);
         chk("t3.stall0", stall0, i >= 3);
         chk("t3.err", err, i >= 5);
      end
      idle_in();
      rb_if.out_ready = 1;
      repeat (6) step("t3.drain");

      // position held while last_kernel=0
      hard_reset("t4r");
      rb_if.out_ready = 1;
      start(4, 4);
      rr.delete(); cc.delete();
      for (int i = 0; i < 7; i++) begin
         v0 = i < 4; lk0 = (i >= 2); d0 = $urandom;
         step("t4");
         if (rb_if.out_valid) begin
            rr.push_back(int'(rb_if.out_row));
            cc.push_back(int'(rb_if.out_col));
         end
      end
      chk("t4.count", rr.size(), 4);
      for (int k = 0; k < 4 && k < rr.size(); k++) begin
         chk("t4.row", rr[k], 0);
         chk("t4.col", cc[k], (k == 3) ? 1 : 0);
      end

      // reset mid-layer with FIFO content
      hard_reset("t5pre");
      rb_if.out_ready = 0;
      start(4, 4);
      for (int i = 0; i < 3; i++) begin
         v0 = 1; lk0 = 1; d0 = $urandom;
         step("t5.fill");
      end
      hard_reset("t5r");
      rb_if.out_ready = 1;
      for (int i = 0; i < 5; i++) begin
         v0 = 1; lk0 = 1; d0 = $urandom;
         step("t5.after");
         chk("t5.silent", rb_if.out_valid, 0);
      end
      idle_in();

      // cols=0 treated as 1, single-beat layer
      start(1, 0);
      v0 = 1; v1 = 1; lk0 = 1; lk1 = 1; d0 = $urandom; d1 = $urandom;
      step("t6.beat");
      wait_done("t6", 20);
      chk("t6.err", err, 0);

      // randomized layers, CEs mostly honour stall
      for (int L = 0; L < 4; L++) begin
         bit fin_l = 0;
         start(int'($urandom_range(1, 3)), int'($urandom_range(0, 3)));
         for (int i = 0; i < 400 && !fin_l; i++) begin
            v0 = ($urandom % 4 != 0) && (!stall0 || $urandom % 8 == 0);
            v1 = ($urandom % 4 != 0) && (!stall1 || $urandom % 8 == 0);
            lk0 = $urandom % 3 != 0; lk1 = $urandom % 3 != 0;
            d0 = $urandom; d1 = $urandom;
            rb_if.out_ready = $urandom % 4 != 0;
            cfg_start = (m_st == S_RUN || m_st == S_DRAIN)
                        && ($urandom % 16 == 0);
            if (cfg_start) begin
               cfg_rows = 16'($urandom_range(0, 5));
               cfg_cols = 16'($urandom_range(0, 5));
            end
            step("rnd");
            if (done) fin_l = 1;
         end
         idle_in();
         chk("rnd.layer_done", fin_l, 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
